irq_sequencer: RTL and testbench
================================

Name: irq_sequencer

Overview:
- Sequences interrupt delivery from the Timer0 flag/mask registers to the CPU core.
- Arbitrates among NUM_SRC flagged sources and presents one request and vector at a time.
- Runs a full request/acknowledge/service/return handshake with the core.
- Emits a one-cycle clear pulse for the serviced flag, so the TIFR write-back needs no software involvement.

Parameters:
- NUM_SRC, 3, number of interrupt sources; index 0 = TOV0, 1 = OCF0A, 2 = OCF0B.
- I_ADDR_WIDTH, 10, width of the instruction-memory vector address.
- VECTOR_BASE, 1, vector of source 0.
- VECTOR_STRIDE, 1, vector spacing between consecutive sources.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- src_flag  in  NUM_SRC  raw pending flags (TIFR bits, level)
- src_mask  in  NUM_SRC  per-source enables (TIMSK bits)
- global_ie  in  1  global interrupt enable (SREG I bit)
- irq_ack  in  1  core accepted the request and fetched the vector
- reti  in  1  one-cycle pulse when the core executes RETI
- irq  out  1  interrupt request to the core
- vector  out  I_ADDR_WIDTH  ISR address for the current or last request
- active_id  out  $clog2(NUM_SRC)  index of the current or last granted source
- flag_clr  out  NUM_SRC  one-hot, one-cycle clear strobe to TIFR
- in_service  out  1  high while an ISR is executing

Behaviour:
- Reset is synchronous: clk and reset are the block's clock and reset. Reset drives irq=0, vector=0, active_id=0, flag_clr=0, in_service=0, state=IDLE, rr_ptr=0.
- Reset mid-operation abandons any request or service immediately. Flags live in TIFR, so no pending event is lost.
- eligible = src_flag & src_mask, with every bit gated by global_ie.
- vector = VECTOR_BASE + id*VECTOR_STRIDE, truncated to I_ADDR_WIDTH bits.
- flag_clr is zero every cycle except the single strobe cycle after an ack.
- States:
  - IDLE: if eligible != 0, pick a winner (see arbitration), register irq<=1, vector, active_id; go to REQ. Latency is 1 cycle from eligible to irq.
  - REQ: irq, vector and active_id are frozen; no preemption by a higher-priority source.
    - irq_ack=1: irq<=0, flag_clr[active_id]<=1 for exactly one cycle, in_service<=1; go to SVC.
    - Otherwise, if global_ie=0 or the winner's flag or mask bit drops: withdraw with irq<=0, no flag_clr, go to IDLE.
    - Ack in the same cycle as withdrawal: ack wins.
  - SVC: irq held at 0 regardless of eligible (no nesting). On reti: in_service<=0, go to IDLE. The earliest next irq is 2 cycles after the reti pulse.
- Out-of-state handshake inputs are ignored: irq_ack in IDLE or SVC, and reti in IDLE or REQ.
- vector and active_id hold their last values whenever irq is 0, so the core can read them after ack.
- Arbitration (default): fixed priority, lowest index wins (TOV0 > OCF0A > OCF0B).

Optional Feature:
- Macro: IRQ_ROUND_ROBIN_EN.
- When defined: round-robin arbitration. The search starts at rr_ptr and wraps modulo NUM_SRC. On each irq_ack, rr_ptr <= (active_id+1) mod NUM_SRC. rr_ptr resets to 0 and does not change on withdrawal.
- When undefined: fixed priority as above; no rr_ptr register is present.

Test Plan:
1. global_ie=1, mask=3'b111, flag=3'b001 -> irq=1 next cycle, vector=1, active_id=0. Pulse irq_ack -> irq=0, flag_clr=3'b001 for one cycle, in_service=1.
2. flag=3'b110, mask=3'b111 -> vector=2, active_id=1. After ack, flag=3'b100 and reti: fixed mode grants id 2 (vector=3). With IRQ_ROUND_ROBIN_EN and flag=3'b111 held, the order is 0, 1, 2, 0.
3. irq pending in REQ, global_ie dropped to 0 before ack -> irq=0 next cycle, vector stays 1, flag_clr stays 0, state IDLE.
4. In SVC, flag=3'b010 asserted -> irq stays 0. reti pulse at cycle t -> irq=1 at t+2 with vector=2.
5. reset asserted in REQ and again in SVC -> next cycle irq=0, vector=0, in_service=0, flag_clr=0.
6. flag=3'b100, mask=3'b011, global_ie=1 -> irq never asserts; flag=3'b001 with global_ie=0 -> irq never asserts.

Source files
------------

// File: rtl/irq_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : irq_sequencer
// Purpose  : Arbitrates Timer0 interrupt flags and runs the request / ack /
//            service / return handshake with the core, strobing TIFR clear.
// Options  : define IRQ_ROUND_ROBIN_EN for round-robin arbitration
//            (default build: fixed priority, lowest index wins).
// Revision : 1.0 - initial release
// ============================================================================
module irq_sequencer #(
   parameter int NUM_SRC       = 3,
   parameter int I_ADDR_WIDTH  = 10,
   parameter int VECTOR_BASE   = 1,
   parameter int VECTOR_STRIDE = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_SRC-1:0]         src_flag,
   input  logic [NUM_SRC-1:0]         src_mask,
   input  logic                       global_ie,
   input  logic                       irq_ack,
   input  logic                       reti,
   output logic                       irq,
   output logic [I_ADDR_WIDTH-1:0]    vector,
   output logic [$clog2(NUM_SRC)-1:0] active_id,
   output logic [NUM_SRC-1:0]         flag_clr,
   output logic                       in_service
);

   localparam int ID_W = $clog2(NUM_SRC);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      SVC  = 2'd2
   } state_t;

   state_t                  state;
   logic [NUM_SRC-1:0]      eligible;
   logic [ID_W-1:0]         win_id;
   logic [I_ADDR_WIDTH-1:0] win_vec;
   logic                    withdraw;

   assign eligible = src_flag & src_mask & {NUM_SRC{global_ie}};

`ifdef IRQ_ROUND_ROBIN_EN
   logic [ID_W-1:0] rr_ptr;
   int              best;
   int              dist;

   // Winner is the eligible source at the smallest circular distance from rr_ptr.
   always_comb begin
      win_id = '0;
      best   = NUM_SRC;
      dist   = 0;
      for (int i = 0; i < NUM_SRC; i++) begin
         dist = (i + NUM_SRC - int'(rr_ptr)) % NUM_SRC;
         if (eligible[i] && (dist < best)) begin
            best   = dist;
            win_id = ID_W'(i);
         end
      end
   end
`else
   always_comb begin
      win_id = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) win_id = ID_W'(i);
      end
   end
`endif

   assign win_vec  = I_ADDR_WIDTH'(VECTOR_BASE)
                   + I_ADDR_WIDTH'(win_id) * I_ADDR_WIDTH'(VECTOR_STRIDE);

   // The granted request is withdrawn once its own source stops being eligible.
   assign withdraw = !global_ie || !src_flag[active_id] || !src_mask[active_id];

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         irq        <= 1'b0;
         vector     <= '0;
         active_id  <= '0;
         flag_clr   <= '0;
         in_service <= 1'b0;
`ifdef IRQ_ROUND_ROBIN_EN
         rr_ptr     <= '0;
`endif
      end else begin
         flag_clr <= '0;
         case (state)
            IDLE: begin
               if (|eligible) begin
                  irq       <= 1'b1;
                  vector    <= win_vec;
                  active_id <= win_id;
                  state     <= REQ;
               end
            end
            REQ: begin
               if (irq_ack) begin
                  irq                 <= 1'b0;
                  flag_clr[active_id] <= 1'b1;
                  in_service          <= 1'b1;
                  state               <= SVC;
`ifdef IRQ_ROUND_ROBIN_EN
                  rr_ptr <= (active_id == ID_W'(NUM_SRC - 1)) ? '0
                                                               : active_id + ID_W'(1);
`endif
               end else if (withdraw) begin
                  irq   <= 1'b0;
                  state <= IDLE;
               end
            end
            SVC: begin
               if (reti) begin
                  in_service <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_irq_sequencer.sv
`default_nettype none
// Testbench for irq_sequencer: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_irq_sequencer;

   localparam int N  = 3;
   localparam int AW = 10;
   localparam int VB = 1;
   localparam int VS = 1;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  src_flag;
   logic [N-1:0]  src_mask;
   logic          global_ie;
   logic          irq_ack;
   logic          reti;
   logic          irq;
   logic [AW-1:0] vector;
   logic [1:0]    active_id;
   logic [N-1:0]  flag_clr;
   logic          in_service;

   int tests = 0;
   int fails = 0;

   irq_sequencer #(
      .NUM_SRC(N), .I_ADDR_WIDTH(AW), .VECTOR_BASE(VB), .VECTOR_STRIDE(VS)
   ) dut (
      .clk(clk), .reset(reset), .src_flag(src_flag), .src_mask(src_mask),
      .global_ie(global_ie), .irq_ack(irq_ack), .reti(reti), .irq(irq),
      .vector(vector), .active_id(active_id), .flag_clr(flag_clr),
      .in_service(in_service)
   );

   always #5 clk = ~clk;

   // Reference model: phase 0 = waiting, 1 = request outstanding, 2 = ISR running.
   int            m_phase;
   logic          m_irq;
   logic [AW-1:0] m_vec;
   int            m_id;
   logic [N-1:0]  m_clr;
   logic          m_svc;
   int            m_rr;

   function automatic int pick(input logic [N-1:0] elig, input int rr);
`ifdef IRQ_ROUND_ROBIN_EN
      for (int k = 0; k < N; k++) if (elig[(rr + k) % N]) return (rr + k) % N;
`else
      for (int i = 0; i < N; i++) if (elig[i]) return i;
`endif
      return -1;
   endfunction

   task automatic model_step();
      logic [N-1:0] elig;
      int w;
      elig = global_ie ? (src_flag & src_mask) : '0;
      if (reset) begin
         m_phase = 0; m_irq = 0; m_vec = '0; m_id = 0; m_clr = '0; m_svc = 0; m_rr = 0;
         return;
      end
      m_clr = '0;
      if (m_phase == 0) begin
         w = pick(elig, m_rr);
         if (w >= 0) begin
            m_irq = 1; m_id = w; m_vec = AW'(VB + w * VS); m_phase = 1;
         end
      end else if (m_phase == 1) begin
         if (irq_ack) begin
            m_irq = 0; m_clr = N'(1 << m_id); m_svc = 1; m_rr = (m_id + 1) % N; m_phase = 2;
         end else if (!global_ie || !src_flag[m_id] || !src_mask[m_id]) begin
            m_irq = 0; m_phase = 0;
         end
      end else if (reti) begin
         m_svc = 0; m_phase = 0;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_model();
      chk("irq", 32'(irq), 32'(m_irq));
      chk("vector", 32'(vector), 32'(m_vec));
      chk("active_id", 32'(active_id), 32'(m_id));
      chk("flag_clr", 32'(flag_clr), 32'(m_clr));
      chk("in_service", 32'(in_service), 32'(m_svc));
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   int exp_order[4];
   int t_irq_max;

   initial begin
`ifdef IRQ_ROUND_ROBIN_EN
      exp_order = '{0, 1, 2, 0};
`else
      exp_order = '{0, 0, 0, 0};
`endif
      reset = 1; src_flag = '0; src_mask = '0; global_ie = 0; irq_ack = 0; reti = 0;
      ticks(2);
      chk("reset_irq", 32'(irq), 0);
      chk("reset_vector", 32'(vector), 0);
      chk("reset_in_service", 32'(in_service), 0);
      reset = 0;
      tick();

      // Single source grant, ack and clear strobe
      global_ie = 1; src_mask = 3'b111; src_flag = 3'b001;
      tick();
      chk("t1_irq", 32'(irq), 1);
      chk("t1_vector", 32'(vector), 1);
      chk("t1_id", 32'(active_id), 0);
      irq_ack = 1; tick(); irq_ack = 0; src_flag = 3'b000;
      chk("t1_ack_irq", 32'(irq), 0);
      chk("t1_clr", 32'(flag_clr), 3'b001);
      chk("t1_insvc", 32'(in_service), 1);
      tick();
      chk("t1_clr_once", 32'(flag_clr), 0);
      reti = 1; tick(); reti = 0; tick();

      // Two pending, then remaining one after return
      src_flag = 3'b110; tick();
      chk("t2_vector", 32'(vector), 2);
      chk("t2_id", 32'(active_id), 1);
      irq_ack = 1; tick(); irq_ack = 0; src_flag = 3'b100;
      reti = 1; tick(); reti = 0; tick();
      chk("t2_next_irq", 32'(irq), 1);
      chk("t2_next_vector", 32'(vector), 3);
      irq_ack = 1; tick(); irq_ack = 0; src_flag = 3'b000;
      reti = 1; tick(); reti = 0;

      // Grant order with all three held pending
      reset = 1; tick(); reset = 0; src_flag = 3'b111;
      for (int n = 0; n < 4; n++) begin
         tick();
         chk("order_irq", 32'(irq), 1);
         chk("order_id", 32'(active_id), 32'(exp_order[n]));
         irq_ack = 1; tick(); irq_ack = 0;
         reti = 1; tick(); reti = 0;
      end
      src_flag = 3'b000; tick();

      // Withdrawal when global_ie drops before ack
      reset = 1; tick(); reset = 0; src_flag = 3'b001; tick();
      global_ie = 0; tick();
      chk("t3_irq", 32'(irq), 0);
      chk("t3_vector", 32'(vector), 1);
      chk("t3_clr", 32'(flag_clr), 0);
      ticks(2);
      chk("t3_idle", 32'(irq), 0);
      global_ie = 1; src_flag = 3'b000; tick();

      // No nesting during service; re-request two cycles after reti
      src_flag = 3'b001; tick(); irq_ack = 1; tick(); irq_ack = 0;
      src_flag = 3'b010; ticks(3);
      chk("t4_no_nest", 32'(irq), 0);
      reti = 1; tick(); reti = 0;
      chk("t4_t1_irq", 32'(irq), 0);
      tick();
      chk("t4_t2_irq", 32'(irq), 1);
      chk("t4_t2_vector", 32'(vector), 2);

      // Reset abandons request and service
      reset = 1; tick(); reset = 0;
      chk("t5_req_irq", 32'(irq), 0);
      chk("t5_req_vector", 32'(vector), 0);
      src_flag = 3'b001; tick(); irq_ack = 1; tick(); irq_ack = 0;
      reset = 1; tick(); reset = 0;
      chk("t5_svc_insvc", 32'(in_service), 0);
      chk("t5_svc_clr", 32'(flag_clr), 0);
      chk("t5_svc_irq", 32'(irq), 0);

      // Masked source and disabled global enable never request
      src_flag = 3'b100; src_mask = 3'b011; global_ie = 1;
      t_irq_max = 0;
      for (int i = 0; i < 5; i++) begin tick(); if (irq) t_irq_max = 1; end
      chk("t6_masked", 32'(t_irq_max), 0);
      src_flag = 3'b001; src_mask = 3'b111; global_ie = 0;
      for (int i = 0; i < 5; i++) begin tick(); if (irq) t_irq_max = 1; end
      chk("t6_gie_off", 32'(t_irq_max), 0);

      // Randomized traffic against the model
      for (int c = 0; c < 2000; c++) begin
         src_flag  = N'($urandom);
         src_mask  = ($urandom_range(0, 3) == 0) ? N'($urandom) : 3'b111;
         global_ie = ($urandom_range(0, 7) != 0);
         irq_ack   = m_irq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
         reti      = m_svc ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
         reset     = ($urandom_range(0, 199) == 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
